// File: rtl/formula_sum_isqrt_par_fsm.sv
// ============================================================================
// formula_sum_isqrt_par_fsm : res = sum of isqrt(x_i) over N_ARGS args, N_ISQRT lanes/round
// Optional: FORMULA_SUM_ISQRT_ERR_EN adds isqrt_err.      Rev 1.0 initial release
// ============================================================================
`default_nettype none

module formula_sum_isqrt_par_fsm #(
  parameter int N_ARGS  = 3,
  parameter int N_ISQRT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef FORMULA_SUM_ISQRT_ERR_EN
  output logic                   isqrt_err,
`endif
  input  logic                   arg_vld,
  output logic                   arg_rdy,
  input  logic [N_ARGS*32-1:0]   args,
  output logic                   res_vld,
  output logic [31:0]            res,
  output logic [N_ISQRT-1:0]     isqrt_x_vld,
  output logic [N_ISQRT*32-1:0]  isqrt_x,
  input  logic [N_ISQRT-1:0]     isqrt_y_vld,
  input  logic [N_ISQRT*16-1:0]  isqrt_y
);

  localparam int ROUNDS = (N_ARGS + N_ISQRT - 1) / N_ISQRT;
  localparam int RND_W  = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [N_ARGS*32-1:0] args_q, args_d;
  logic [31:0]         acc_q, acc_d;
  logic [RND_W-1:0]    round_q, round_d;
  logic [N_ISQRT-1:0]  pend_q, pend_d;
  logic [31:0]         res_q, res_d;
  logic                res_vld_q, res_vld_d;

  logic [N_ISQRT-1:0]  w_used;
  logic [31:0]         w_sum [N_ISQRT+1];

  assign w_sum[0] = 32'd0;

  // Each lane selects its argument for the current round through an OR-chain
  // over rounds; slots beyond N_ARGS are never selected, so the lane is idle.
  for (genvar j = 0; j < N_ISQRT; j++) begin : g_lane
    logic [31:0] w_data_c [ROUNDS+1];
    logic        w_used_c [ROUNDS+1];

    assign w_data_c[0] = 32'd0;
    assign w_used_c[0] = 1'b0;

    for (genvar r = 0; r < ROUNDS; r++) begin : g_rnd
      if (r * N_ISQRT + j < N_ARGS) begin : g_act
        logic w_sel;
        assign w_sel = (round_q == RND_W'(r));
        assign w_data_c[r+1] = w_data_c[r] |
                               (w_sel ? args_q[32*(r*N_ISQRT+j) +: 32] : 32'd0);
        assign w_used_c[r+1] = w_used_c[r] | w_sel;
      end else begin : g_idle
        assign w_data_c[r+1] = w_data_c[r];
        assign w_used_c[r+1] = w_used_c[r];
      end
    end

    assign isqrt_x[32*j +: 32] = w_data_c[ROUNDS];
    assign w_used[j]           = w_used_c[ROUNDS];
    // Only responses on pending lanes contribute to the sum.
    assign w_sum[j+1] = w_sum[j] +
                        ((pend_q[j] & isqrt_y_vld[j]) ? {16'd0, isqrt_y[16*j +: 16]} : 32'd0);
  end

  always_comb begin
    state_d     = state_q;
    args_d      = args_q;
    acc_d       = acc_q;
    round_d     = round_q;
    pend_d      = pend_q;
    res_d       = res_q;
    res_vld_d   = 1'b0;
    arg_rdy     = 1'b0;
    isqrt_x_vld = '0;
    case (state_q)
      ST_IDLE: begin
        arg_rdy = 1'b1;
        if (arg_vld) begin
          args_d  = args;
          acc_d   = 32'd0;
          round_d = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        isqrt_x_vld = w_used;
        pend_d      = w_used;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        acc_d  = acc_q + w_sum[N_ISQRT];
        pend_d = pend_q & ~isqrt_y_vld;
        if (pend_d == '0) begin
          if (round_q == RND_W'(ROUNDS - 1)) begin
            res_d     = acc_d;
            res_vld_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            round_d = round_q + RND_W'(1);
            state_d = ST_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      args_q    <= '0;
      acc_q     <= 32'd0;
      round_q   <= '0;
      pend_q    <= '0;
      res_q     <= 32'd0;
      res_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      args_q    <= args_d;
      acc_q     <= acc_d;
      round_q   <= round_d;
      pend_q    <= pend_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
    end
  end

  assign res     = res_q;
  assign res_vld = res_vld_q;

`ifdef FORMULA_SUM_ISQRT_ERR_EN
  logic isqrt_err_q, isqrt_err_d;

  always_comb begin
    isqrt_err_d = |(isqrt_y_vld & ~pend_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      isqrt_err_q <= 1'b0;
    end else begin
      isqrt_err_q <= isqrt_err_d;
    end
  end

  assign isqrt_err = isqrt_err_q;
`endif

endmodule

`default_nettype wire
